// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared state encoding and latency helper for seq_mul
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Worst-case start-to-done cycle count, used by the stall controller
    function automatic int lat(input int width, input int bpc);
        return width / bpc + 2;
    endfunction

endpackage

// File: rtl/seq_mul_if.sv
// rtl/seq_mul_if.sv - start/busy/done multiplier request and result bundle
interface seq_mul_if #(
    parameter int WIDTH = 32
) ();
    logic                 start;
    logic                 signed_op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   z;

    modport master (output start, signed_op, a, b, input busy, done, z);
    modport slave  (input start, signed_op, a, b, output busy, done, z);
endinterface

// File: rtl/seq_mul_step.sv
// rtl/seq_mul_step.sv - one BPC-bit x WIDTH partial product shifted into the accumulator
module seq_mul_step #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1,
    parameter int CW    = 6
) (
    input  logic [BPC-1:0]     bits,
    input  logic [WIDTH-1:0]   ma,
    input  logic [CW-1:0]      cnt,
    input  logic [2*WIDTH-1:0] acc_in,
    output logic [2*WIDTH-1:0] acc_out
);
    logic [WIDTH+BPC-1:0] pp;
    logic [2*WIDTH-1:0]   pp_ext;

    assign pp      = {{BPC{1'b0}}, ma} * {{WIDTH{1'b0}}, bits};
    assign pp_ext  = {{(WIDTH-BPC){1'b0}}, pp};
    assign acc_out = acc_in + (pp_ext << (int'(cnt) * BPC));
endmodule

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - multi-cycle shift-add MULT/MULTU unit; SEQ_MUL_EARLY_TERM_EN enables early termination
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic  clk,
    input  logic  rst,
    seq_mul_if.slave bus
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t               state, state_n;
    logic [WIDTH-1:0]     ma, mb;
    logic                 neg;
    logic [2*WIDTH-1:0]   acc, acc_step, acc_fix, z_r;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 mb_zero;

    assign a_mag   = (bus.signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag   = (bus.signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign acc_fix = neg ? -acc : acc;

`ifdef SEQ_MUL_EARLY_TERM_EN
    // No multiplier bits left: the remaining partial products are all zero
    assign mb_zero = (mb == '0);
`else
    assign mb_zero = 1'b0;
`endif

    seq_mul_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC),
        .CW    (CW)
    ) u_step (
        .bits    (mb[BPC-1:0]),
        .ma      (ma),
        .cnt     (cnt),
        .acc_in  (acc),
        .acc_out (acc_step)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = RUN;
            RUN:     if (mb_zero || cnt == LAST) state_n = FIX;
            FIX:     state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ma    <= '0;
            mb    <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            z_r   <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (bus.start) begin
                    ma  <= a_mag;
                    mb  <= b_mag;
                    neg <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc <= '0;
                    cnt <= '0;
                end
                RUN: if (!mb_zero) begin
                    acc <= acc_step;
                    mb  <= mb >> BPC;
                    cnt <= cnt + CW'(1);
                end
                // z is loaded here so it is already valid in the DONE cycle
                FIX: begin
                    acc <= acc_fix;
                    z_r <= acc_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == RUN) || (state == FIX);
    assign bus.done = (state == DONE);
    assign bus.z    = z_r;
endmodule
